// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: command-side ALU driver that repeats
// 1-bit shift/rotate ops N times by feeding Out back into A.
//
// Ports:
//   clk, reset            single clock, sync active-high reset
//   cmd_valid/cmd_ready   command handshake (op, a, b, shamt)
//   cmd_op/a/b/shamt      command payload
//   alu_a/alu_b/alu_op    operands and op to the combinational ALU
//   alu_out/alu_zero      ALU result and zero flag
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_zero     registered result and zero flag
//   busy                  high whenever not idle
module alu_shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   b;
  logic [3:0]         op;
  logic [SHAMT_W-1:0] cnt;
  logic               zf;

  logic load;
  logic step;
  logic fin;
  logic shift_cls;

  // Only these codes repeat; anything else runs exactly once.
  always_comb begin
    shift_cls = 1'b0;
    unique case (1'b1)
      (cmd_op == 4'b1000): shift_cls = 1'b1;
      (cmd_op == 4'b1001): shift_cls = 1'b1;
      (cmd_op == 4'b1010): shift_cls = 1'b1;
      (cmd_op == 4'b1100): shift_cls = 1'b1;
      (cmd_op == 4'b1101): shift_cls = 1'b1;
      default:             shift_cls = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          step = 1'b1;
        end else begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      b        <= '0;
      op       <= '0;
      cnt      <= '0;
      zf       <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (load) begin
        acc <= cmd_a;
        b   <= cmd_b;
        op  <= cmd_op;
        zf  <= (cmd_a == '0);
        cnt <= shift_cls ? cmd_shamt
                         : SHAMT_W'(1);
      end
      if (step) begin
        acc <= alu_out;
        zf  <= alu_zero;
        cnt <= cnt - SHAMT_W'(1);
      end
      if (fin) begin
        rsp_data <= acc;
        rsp_zero <= zf;
      end
    end
  end

  assign alu_a     = acc;
  assign alu_b     = b;
  assign alu_op    = op;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

endmodule
